// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the otter_mcu memory arbiter.
package otter_arb_pkg;

  localparam int unsigned STARVE_W = 4;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_I    = 2'd1,
    TAG_D    = 2'd2
  } resp_tag_t;

endpackage

// File: rtl/otter_arb_starve_ctr.sv
// Saturating count of consecutive cycles the fetch port has been denied.
// sat tells the arbiter to hand the next contended cycle to fetch.
module otter_arb_starve_ctr
  import otter_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(MAX_WAIT);

  logic [STARVE_W-1:0] cnt;

  // Clear has priority; increments stop once the limit is reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_CNT)) begin
      cnt <= cnt + STARVE_W'(1);
    end
  end

  assign sat = (cnt == MAX_CNT);

endmodule

// File: rtl/otter_mem_arbiter.sv
// Single-port memory arbiter for the otter_mcu fetch and data ports.
// One grant per cycle, one-cycle read latency routed back by a response tag,
// and a LOCK state that keeps fetch out between an AMO read and its write.
// Optional: define OTTER_ARB_PERF_EN to add three free-running perf counters.
module otter_mem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int unsigned MEM_EXP  = 28,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [31:0]          i_addr,
  output logic                 i_gnt,
  output logic                 i_rvalid,
  output logic [31:0]          i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic                 d_lock,
  input  logic [3:0]           d_strb,
  input  logic [31:0]          d_addr,
  input  logic [31:0]          d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [31:0]          d_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [3:0]           mem_strb,
  output logic [MEM_EXP-3:0]   mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
`ifdef OTTER_ARB_PERF_EN
  ,
  output logic [31:0]          perf_conflicts,
  output logic [31:0]          perf_fetch_stall,
  output logic [31:0]          perf_lock_cycles
`endif
);

  arb_state_t  state;
  resp_tag_t   resp_tag;
  logic        resp_rd;
  logic        starve_sat;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:MEM_EXP], i_addr[1:0],
                              d_addr[31:MEM_EXP], d_addr[1:0]};

  otter_arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk(clk),
    .rst(rst),
    .inc(i_req & ~i_gnt),
    .clr(i_gnt | ~i_req),
    .sat(starve_sat)
  );

  // Grant selection: data wins contention unless fetch has starved; LOCK shuts fetch out.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      if (state == LOCK) begin
        d_gnt = d_req;
      end else if (i_req && d_req) begin
        if (starve_sat) i_gnt = 1'b1;
        else            d_gnt = 1'b1;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end

  assign mem_en    = i_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_strb  = d_we ? d_strb : '0;
  assign mem_addr  = d_gnt ? d_addr[MEM_EXP-1:2] : i_addr[MEM_EXP-1:2];
  assign mem_wdata = d_wdata;

  // Enter LOCK on a locked read; leave after the first granted unlocked access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB;
    end else begin
      case (state)
        ARB:     if (d_gnt && d_lock && !d_we) state <= LOCK;
        LOCK:    if (d_gnt && !d_lock)         state <= ARB;
        default: state <= ARB;
      endcase
    end
  end

  // Remember who owns the in-flight memory response and hold each port's last data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_tag  <= TAG_NONE;
      resp_rd   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_gnt)      resp_tag <= TAG_I;
      else if (d_gnt) resp_tag <= TAG_D;
      else            resp_tag <= TAG_NONE;
      resp_rd   <= ~d_we;
      i_rdata_q <= i_rdata;
      d_rdata_q <= d_rdata;
    end
  end

  // Memory data passes straight through in the response cycle so rdata aligns with
  // rvalid; the holding registers supply the value at all other times.
  always_comb begin
    i_rvalid = (resp_tag == TAG_I);
    d_rvalid = (resp_tag == TAG_D);
    i_rdata  = i_rvalid ? mem_rdata : i_rdata_q;
    d_rdata  = (d_rvalid && resp_rd) ? mem_rdata : d_rdata_q;
  end

`ifdef OTTER_ARB_PERF_EN
  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_conflicts   <= '0;
      perf_fetch_stall <= '0;
      perf_lock_cycles <= '0;
    end else begin
      if (i_req && d_req)   perf_conflicts   <= perf_conflicts + 32'd1;
      if (i_req && !i_gnt)  perf_fetch_stall <= perf_fetch_stall + 32'd1;
      if (state == LOCK)    perf_lock_cycles <= perf_lock_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed self-checking bench for otter_mem_arbiter with a response scoreboard.
module tb_otter_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic        d_lock;
  logic [3:0]  d_strb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_strb;
  logic [25:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  otter_mem_arbiter #(
    .MEM_EXP(28),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_strb(d_strb), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_strb(mem_strb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port word memory with byte strobes.
  logic [31:0] mem [logic [25:0]];
  logic [31:0] wtmp;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        wtmp = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (mem_strb[b]) wtmp[b*8 +: 8] = mem_wdata[b*8 +: 8];
        mem[mem_addr] = wtmp;
      end else begin
        mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
      end
    end
  end

  typedef struct {
    bit          is_d;
    bit          is_wr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] i_last = 32'h0;
  logic [31:0] d_last = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check grants at the sampling point and queue the response the grant should produce.
  task automatic gchk(input string tag, input logic ei, input logic ed, input bit push,
                      input logic [31:0] edata);
    exp_t e;
    chk({tag, ".i_gnt"},  {31'b0, i_gnt},  {31'b0, ei});
    chk({tag, ".d_gnt"},  {31'b0, d_gnt},  {31'b0, ed});
    chk({tag, ".mem_en"}, {31'b0, mem_en}, {31'b0, ei | ed});
    if (push && (ei || ed)) begin
      e.is_d  = ed;
      e.is_wr = ed && d_we;
      e.data  = edata;
      e.cyc   = cyc;
      q.push_back(e);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a response is owed exactly one cycle after its grant; idle ports hold.
  exp_t       mon_f;
  bit         mon_hit;
  logic [1:0] exp_pair;
  always @(negedge clk) begin
    mon_hit = (q.size() > 0) && (q[0].cyc == cyc - 1);
    if (mon_hit) mon_f = q.pop_front();
    exp_pair = mon_hit ? {~mon_f.is_d, mon_f.is_d} : 2'b00;
    chk("rvalid{i,d}", {30'b0, i_rvalid, d_rvalid}, {30'b0, exp_pair});
    if (mon_hit && !mon_f.is_d) i_last = mon_f.data;
    if (mon_hit && mon_f.is_d && !mon_f.is_wr) d_last = mon_f.data;
    chk("i_rdata", i_rdata, i_last);
    chk("d_rdata", d_rdata, d_last);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[26'h0000400] = 32'h00000013;
    mem[26'h0000401] = 32'h00100093;
    mem[26'h0000800] = 32'h11223344;
    mem[26'h0000C00] = 32'h55667788;
    mem[26'h0001000] = 32'hCAFEF00D;
    mem_rdata = 32'h0;
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h8000_1000;
    d_req = 1'b1; d_we = 1'b0; d_lock = 1'b0; d_strb = 4'h0;
    d_addr = 32'h8000_2000; d_wdata = 32'h0;

    // Reset: requests present but nothing granted or returned.
    #2;
    chk("rst.i_gnt",    {31'b0, i_gnt},    32'h0);
    chk("rst.d_gnt",    {31'b0, d_gnt},    32'h0);
    chk("rst.mem_en",   {31'b0, mem_en},   32'h0);
    chk("rst.i_rvalid", {31'b0, i_rvalid}, 32'h0);
    chk("rst.d_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("rst.i_rdata",  i_rdata,           32'h0);
    chk("rst.d_rdata",  d_rdata,           32'h0);
    nxt();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    nxt();

    // 1: fetch only.
    i_req = 1'b1; i_addr = 32'h8000_1000;
    @(negedge clk);
    gchk("t1", 1'b1, 1'b0, 1'b1, 32'h00000013);
    chk("t1.mem_addr", {6'b0, mem_addr}, 32'h0000_0400);
    chk("t1.mem_we",   {31'b0, mem_we},  32'h0);
    nxt();
    i_req = 1'b0;
    @(negedge clk); gchk("t1.idle", 1'b0, 1'b0, 1'b0, 32'h0); nxt();

    // 2: continuous contention, fetch forced in after 4 denials.
    i_req = 1'b1; i_addr = 32'h8000_1004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_2000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k % 5 == 4) gchk("t2", 1'b1, 1'b0, 1'b1, 32'h00100093);
      else            gchk("t2", 1'b0, 1'b1, 1'b1, 32'h11223344);
      nxt();
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk); gchk("t2.idle", 1'b0, 1'b0, 1'b0, 32'h0); nxt();

    // 3: byte write, ack leaves d_rdata alone, then read back the merged word.
    d_req = 1'b1; d_we = 1'b1; d_strb = 4'b0010;
    d_addr = 32'h8000_4000; d_wdata = 32'hAABBCCDD;
    @(negedge clk);
    gchk("t3.wr", 1'b0, 1'b1, 1'b1, 32'h0);
    chk("t3.mem_we",    {31'b0, mem_we},   32'h1);
    chk("t3.mem_strb",  {28'b0, mem_strb}, 32'h2);
    chk("t3.mem_wdata", mem_wdata,         32'hAABBCCDD);
    chk("t3.mem_addr",  {6'b0, mem_addr},  32'h0000_1000);
    nxt();
    d_req = 1'b0; d_we = 1'b0; d_strb = 4'h0;
    @(negedge clk); gchk("t3.idle", 1'b0, 1'b0, 1'b0, 32'h0); nxt();
    d_req = 1'b1;
    @(negedge clk); gchk("t3.rd", 1'b0, 1'b1, 1'b1, 32'hCAFECC0D); nxt();
    d_req = 1'b0;
    @(negedge clk); gchk("t3.idle2", 1'b0, 1'b0, 1'b0, 32'h0); nxt();

    // 4: locked read, fetch shut out through LOCK, starved fetch wins after exit.
    i_req = 1'b1; i_addr = 32'h8000_1000;
    d_req = 1'b1; d_lock = 1'b1; d_we = 1'b0; d_addr = 32'h8000_3000;
    @(negedge clk); gchk("t4.lockrd", 1'b0, 1'b1, 1'b1, 32'h55667788); nxt();
    d_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); gchk("t4.locked", 1'b0, 1'b0, 1'b0, 32'h0); nxt();
    end
    d_req = 1'b1; d_we = 1'b1; d_lock = 1'b0; d_strb = 4'hF; d_wdata = 32'h12345678;
    @(negedge clk); gchk("t4.amowr", 1'b0, 1'b1, 1'b1, 32'h0); nxt();
    d_we = 1'b0; d_strb = 4'h0; d_addr = 32'h8000_2000;
    @(negedge clk); gchk("t4.resume", 1'b1, 1'b0, 1'b1, 32'h00000013); nxt();
    @(negedge clk); gchk("t4.after", 1'b0, 1'b1, 1'b1, 32'h11223344); nxt();
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk); gchk("t4.idle", 1'b0, 1'b0, 1'b0, 32'h0); nxt();

    // 5: alternating I, D, I back to back.
    i_req = 1'b1; i_addr = 32'h8000_1004;
    @(negedge clk); gchk("t5.i0", 1'b1, 1'b0, 1'b1, 32'h00100093); nxt();
    i_req = 1'b0; d_req = 1'b1; d_addr = 32'h8000_3000;
    @(negedge clk); gchk("t5.d", 1'b0, 1'b1, 1'b1, 32'h12345678); nxt();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h8000_1000;
    @(negedge clk); gchk("t5.i1", 1'b1, 1'b0, 1'b1, 32'h00000013); nxt();
    i_req = 1'b0;
    @(negedge clk); gchk("t5.idle", 1'b0, 1'b0, 1'b0, 32'h0); nxt();

    // 6: reset right after a data grant drops its response immediately.
    d_req = 1'b1; d_addr = 32'h8000_2000;
    @(negedge clk); gchk("t6.d", 1'b0, 1'b1, 1'b0, 32'h0); nxt();
    rst = 1'b0;
    #1;
    i_last = 32'h0; d_last = 32'h0;
    chk("t6.d_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("t6.i_rvalid", {31'b0, i_rvalid}, 32'h0);
    chk("t6.d_rdata",  d_rdata,           32'h0);
    chk("t6.i_rdata",  i_rdata,           32'h0);
    chk("t6.d_gnt",    {31'b0, d_gnt},    32'h0);
    chk("t6.mem_en",   {31'b0, mem_en},   32'h0);
    @(negedge clk); gchk("t6.inrst", 1'b0, 1'b0, 1'b0, 32'h0); nxt();
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk); gchk("t6.idle", 1'b0, 1'b0, 1'b0, 32'h0); nxt();
    i_req = 1'b1; i_addr = 32'h8000_1000;
    @(negedge clk); gchk("t6.fetch", 1'b1, 1'b0, 1'b1, 32'h00000013); nxt();
    i_req = 1'b0;
    @(negedge clk); gchk("t6.idle2", 1'b0, 1'b0, 1'b0, 32'h0); nxt();
    @(negedge clk); nxt();

    chk("scoreboard_empty", q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
Shares one synchronous single-port word memory between the otter_mcu instruction-fetch port and data port. It is the structural replacement for the dual-ported behavioural prog_mem used in simulation, so the same core runs against one real SRAM macro or BRAM. It grants one requester per cycle, routes the one-cycle-latency read data back to the correct port, and supports a locked read-modify-write sequence for atomics.

Parameters:
MEM_EXP, 28, log2 of memory size in bytes; the memory word address is addr[MEM_EXP-1:2].
MAX_WAIT, 4, consecutive denied fetch cycles before fetch gets forced priority; range 1..15.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
i_req  in  1  fetch request; held with i_addr until i_gnt
i_addr  in  32  fetch byte address
i_gnt  out  1  fetch accepted this cycle
i_rvalid  out  1  fetch data valid; one cycle after i_gnt
i_rdata  out  32  fetch data; holds the last value between responses
d_req  in  1  data request; held with its fields until d_gnt
d_we  in  1  1 = write, 0 = read
d_lock  in  1  begin or continue a locked sequence
d_strb  in  4  byte write strobes
d_addr  in  32  data byte address
d_wdata  in  32  write data
d_gnt  out  1  data accepted this cycle
d_rvalid  out  1  read data valid or write ack; one cycle after d_gnt
d_rdata  out  32  data read value; holds the last value between responses
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_strb  out  4  memory byte strobes
mem_addr  out  MEM_EXP-2  memory word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- Reset (rst=0, async): FSM=ARB, starve_cnt=0, resp_tag=NONE, i_rvalid=d_rvalid=0, i_rdata=d_rdata=0. Grants and mem_en are combinationally 0 while in reset.
- Grants are combinational from req and state. At most one grant per cycle. mem_* is driven from the granted port. mem_en = i_gnt|d_gnt. mem_we = d_gnt&d_we. mem_strb = d_we ? d_strb : 0.
- ARB state:
  - Only one port requesting: that port is granted.
  - Both requesting: data wins, unless starve_cnt==MAX_WAIT, in which case fetch wins.
- starve_cnt:
  - +1 (saturating at MAX_WAIT) on a cycle with i_req&!i_gnt.
  - Cleared on i_gnt or when i_req=0.
- Locking:
  - An ARB d_gnt with d_lock=1 and d_we=0 moves the FSM to LOCK.
  - In LOCK, i_gnt=0. d_req is still granted.
  - A granted d_req with d_lock=0 returns to ARB after that access; this is the normal end via the AMO write.
  - d_lock with d_we=1 in ARB is an ordinary write and does not enter LOCK.
  - starve_cnt keeps counting in LOCK. If it is saturated on exit, fetch wins the first contended ARB cycle.
- Response routing:
  - resp_tag registers I, D or NONE on each grant.
  - The next cycle, the tagged port's rvalid=1 for exactly one cycle.
  - Its rdata register captures mem_rdata for reads. A write ack leaves d_rdata unchanged.
  - The untagged port's rdata holds its value.
- Throughput: back-to-back grants every cycle, with no bubble between ports.
- Asserting reset mid-access drops the pending response; no rvalid is produced.

Optional Feature:
OTTER_ARB_PERF_EN: defining it adds three outputs.
- perf_conflicts (32): cycles with i_req&d_req.
- perf_fetch_stall (32): cycles with i_req&!i_gnt.
- perf_lock_cycles (32): cycles in LOCK.
All three wrap modulo 2^32 and are cleared by reset. Without the macro these ports and counters do not exist, and arbitration behaviour is identical.

Decomposition:
- Package otter_arb_pkg holds:
  - typedef arb_state_t {ARB, LOCK};
  - typedef resp_tag_t {TAG_NONE, TAG_I, TAG_D};
  - the constant STARVE_W=4.
- One natural sub-module, otter_arb_starve_ctr: the saturating starve counter with inputs inc/clr and a sat output.

Test Plan:
1. Fetch only, i_addr=0x80001000, mem_rdata=0x00000013 → i_gnt same cycle; mem_addr=0x0000400; i_rvalid next cycle with i_rdata=0x00000013.
2. i_req and d_req (read 0x80002000) held continuously, MAX_WAIT=4 → grants D,D,D,D,I,D,D,D,D,I…; fetch never waits more than 4 cycles.
3. Data write d_strb=4'b0010, d_wdata=0xAABBCCDD → mem_we=1, mem_strb=0010; d_rvalid next cycle; d_rdata unchanged.
4. Locked read to 0x80003000 then write with d_lock=0, i_req held high → i_gnt=0 for both cycles; ARB resumes and the next contended cycle grants fetch.
5. Alternating grants I,D,I → rvalid and rdata steer to the correct port each cycle; the idle port's rdata stays stable.
6. rst asserted on the cycle after a d_gnt → d_rvalid never pulses; outputs return to reset values immediately, without waiting for a clock edge.
